// File: rtl/dmem_responder_if.sv
// Request/response bus between a core-side load/store initiator and dmem_responder.
// The initiator uses the master modport and the responder uses the slave modport.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Handshaked data-memory responder for the RV32I load/store path.
// It accepts one request at a time, spends WAIT_CYCLES wait states, then performs
// the access and presents a held response until the initiator takes it.
// Optional feature macro: DMEM_MISALIGN_TRAP_EN. When it is defined, misaligned half and
// word accesses fault. When it is undefined, the low address bits are ignored.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,  // power of two, at least 2
    parameter int unsigned WAIT_CYCLES = 2      // 0..15
) (
    input  logic             clk,
    input  logic             rst,
    dmem_responder_if.slave  bus
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        commit;

    // Operation being committed: with zero wait states the commit happens on the
    // accept edge itself, so the live request is used instead of the latched copy.
    logic        op_we;
    logic [31:0] op_addr;
    logic [1:0]  op_size;
    logic        op_uns;
    logic [31:0] op_wdata;

    logic [31:0] mem [DEPTH_WORDS];

    logic [AW-1:0] idx;
    logic          is_byte, is_half;
    logic          oor, misalign, acc_err;
    logic [3:0]    be;
    logic [31:0]   wlanes;
    logic [31:0]   rd_word;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [31:0]   ld_data;

    // Pick the live request in IDLE, the latched request otherwise.
    always_comb begin
        if (state_q == StIdle) begin
            op_we    = bus.req_we;
            op_addr  = bus.req_addr;
            op_size  = bus.req_size;
            op_uns   = bus.req_unsigned;
            op_wdata = bus.req_wdata;
        end else begin
            op_we    = we_q;
            op_addr  = addr_q;
            op_size  = size_q;
            op_uns   = uns_q;
            op_wdata = wdata_q;
        end
    end

    // Address decode, fault detection, byte enables and load extraction.
    always_comb begin
        idx     = op_addr[AW+1:2];
        is_byte = (op_size == 2'b00);
        is_half = (op_size == 2'b01);
        oor     = ({1'b0, op_addr} >= ADDR_LIMIT);
`ifdef DMEM_MISALIGN_TRAP_EN
        misalign = (is_half && op_addr[0]) || (!is_byte && !is_half && (op_addr[1:0] != 2'b00));
`else
        misalign = 1'b0;
`endif
        acc_err = oor || misalign;

        // Store data is replicated across lanes; the byte enables pick the target lanes.
        if (is_byte) begin
            be     = 4'b0001 << op_addr[1:0];
            wlanes = {4{op_wdata[7:0]}};
        end else if (is_half) begin
            be     = op_addr[1] ? 4'b1100 : 4'b0011;
            wlanes = {2{op_wdata[15:0]}};
        end else begin
            be     = 4'b1111;
            wlanes = op_wdata;
        end

        rd_word = mem[idx];
        case (op_addr[1:0])
            2'b00:   ld_byte = rd_word[7:0];
            2'b01:   ld_byte = rd_word[15:8];
            2'b10:   ld_byte = rd_word[23:16];
            default: ld_byte = rd_word[31:24];
        endcase
        ld_half = op_addr[1] ? rd_word[31:16] : rd_word[15:0];

        if (is_byte) begin
            ld_data = op_uns ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
        end else if (is_half) begin
            ld_data = op_uns ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
        end else begin
            ld_data = rd_word;
        end
    end

    // FSM next-state, request latching, response capture and handshake outputs.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        we_d          = we_q;
        addr_d        = addr_q;
        size_d        = size_q;
        uns_d         = uns_q;
        wdata_d       = wdata_q;
        rdata_d       = rdata_q;
        err_d         = err_q;
        commit        = 1'b0;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;

        case (state_q)
            StIdle: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    addr_d  = bus.req_addr;
                    size_d  = bus.req_size;
                    uns_d   = bus.req_unsigned;
                    wdata_d = bus.req_wdata;
                    if (WAIT_CYCLES == 0) begin
                        commit  = 1'b1;
                        state_d = StResp;
                    end else begin
                        cnt_d   = CNT_INIT;
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    commit  = 1'b1;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (commit) begin
            err_d   = acc_err;
            rdata_d = (op_we || acc_err) ? 32'd0 : ld_data;
        end
    end

    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

    // State and latched-request registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage write on the commit edge; contents survive reset but a reset edge blocks the write.
    always_ff @(posedge clk) begin
        if (!rst && commit && op_we && !acc_err) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wlanes[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed test-plan scenarios plus randomized
// traffic checked against a byte-addressed reference memory model.
module tb_dmem_responder;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned W     = 2;

    logic clk;
    logic rst;

    dmem_responder_if bus ();

    dmem_responder #(
        .DEPTH_WORDS (DEPTH),
        .WAIT_CYCLES (W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mm [DEPTH*4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: byte-addressed memory, natural alignment from the access size.
    task automatic model_access(input bit we, input logic [31:0] addr, input logic [1:0] size,
                                input bit uns, input logic [31:0] wdata,
                                output logic [31:0] rdata, output logic err);
        int unsigned nb;
        logic [31:0] base;
        logic [31:0] val;
        logic [31:0] mask;
        nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        err = (addr >= DEPTH * 4);
`ifdef DMEM_MISALIGN_TRAP_EN
        if ((addr % nb) != 0) err = 1'b1;
`endif
        base = addr - (addr % nb);
        rdata = 32'd0;
        if (!err) begin
            if (we) begin
                for (int i = 0; i < int'(nb); i++) mm[base + i] = wdata[8*i +: 8];
            end else begin
                val = 32'd0;
                for (int i = 0; i < int'(nb); i++) val = val | (32'(mm[base + i]) << (8 * i));
                if (nb < 4) begin
                    mask = (32'd1 << (8 * nb)) - 32'd1;
                    if (!uns && val[8*nb-1]) val = val | ~mask;
                end
                rdata = val;
            end
        end
    endtask

    // Drive one request, wait for its response, hold rsp_ready low for 'hold' cycles, then take it.
    task automatic do_req(input bit we, input logic [31:0] addr, input logic [1:0] size,
                          input bit uns, input logic [31:0] wdata, input int hold,
                          output logic [31:0] rdata, output logic err, output int lat,
                          output bit timeout);
        int g;
        timeout = 1'b0;
        lat = 0;
        @(negedge clk);
        bus.req_we       = we;
        bus.req_addr     = addr;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_wdata    = wdata;
        bus.req_valid    = 1'b1;
        g = 0;
        while (bus.req_ready !== 1'b1 && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (g >= 50) timeout = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'($urandom);
        bus.req_addr     = $urandom;
        bus.req_size     = 2'($urandom);
        bus.req_unsigned = 1'($urandom);
        bus.req_wdata    = $urandom;
        do begin
            @(negedge clk);
            lat++;
        end while (bus.rsp_valid !== 1'b1 && lat < 50);
        if (bus.rsp_valid !== 1'b1) timeout = 1'b1;
        repeat (hold) @(negedge clk);
        rdata = bus.rsp_rdata;
        err   = bus.rsp_err;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (bus.req_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_req_ready got=%b exp=1", bus.req_ready);
        end
        n_checks++;
        if (bus.rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_rsp_valid got=%b exp=0", bus.rsp_valid);
        end
        n_checks++;
        if (bus.rsp_rdata !== 32'd0 || bus.rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_rsp_data got=%h/%b exp=0/0", bus.rsp_rdata, bus.rsp_err);
        end
    endtask

    task automatic test_directed();
        logic [31:0] rd, mrd;
        logic        er, mer;
        int          lat;
        bit          to;
        logic [31:0] exp_rd [6];
        bit          we_t [6];
        logic [31:0] ad_t [6];
        logic [1:0]  sz_t [6];
        bit          un_t [6];
        logic [31:0] wd_t [6];
        we_t = '{1, 0, 1, 0, 0, 0};
        ad_t = '{32'h10, 32'h10, 32'h12, 32'h10, 32'h13, 32'h12};
        sz_t = '{2'd2, 2'd2, 2'd0, 2'd2, 2'd0, 2'd1};
        un_t = '{0, 0, 0, 0, 0, 1};
        wd_t = '{32'hDEADBEEF, 0, 32'h55, 0, 0, 0};
        exp_rd = '{32'd0, 32'hDEADBEEF, 32'd0, 32'hDE55BEEF, 32'hFFFFFFDE, 32'h0000DE55};
        for (int i = 0; i < 6; i++) begin
            model_access(we_t[i], ad_t[i], sz_t[i], un_t[i], wd_t[i], mrd, mer);
            do_req(we_t[i], ad_t[i], sz_t[i], un_t[i], wd_t[i], 0, rd, er, lat, to);
            n_checks++;
            if (to || rd !== exp_rd[i] || er !== 1'b0) begin
                n_fail++;
                $display("FAIL directed_%0d got=%h err=%b to=%b exp=%h err=0", i, rd, er, to,
                         exp_rd[i]);
            end
            n_checks++;
            if (lat != int'(W) + 1) begin
                n_fail++; $display("FAIL directed_latency_%0d got=%0d exp=%0d", i, lat, W + 1);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] mrd;
        logic        mer;
        int          g;
        model_access(1'b0, 32'h10, 2'd2, 1'b0, 32'd0, mrd, mer);
        model_access(1'b0, 32'h13, 2'd0, 1'b0, 32'd0, mrd, mer);
        @(negedge clk);
        bus.rsp_ready    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_addr     = 32'h10;
        bus.req_size     = 2'd2;
        bus.req_unsigned = 1'b0;
        bus.req_valid    = 1'b1;
        @(posedge clk);
        #1;
        // Second request stays pending for the whole stalled response.
        bus.req_addr = 32'h13;
        bus.req_size = 2'd0;
        g = 0;
        do begin @(negedge clk); g++; end while (bus.rsp_valid !== 1'b1 && g < 50);
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'hDE55BEEF || bus.rsp_err !== 1'b0
                || bus.req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold_%0d got v=%b d=%h e=%b rdy=%b exp v=1 d=DE55BEEF e=0 rdy=0",
                         i, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.req_ready);
            end
            if (i < 5) @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL post_handshake got rdy=%b v=%b exp rdy=1 v=0", bus.req_ready,
                     bus.rsp_valid);
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.req_ready !== 1'b0) begin
            n_fail++; $display("FAIL second_accept got rdy=%b exp=0", bus.req_ready);
        end
        g = 0;
        while (bus.rsp_valid !== 1'b1 && g < 50) begin @(negedge clk); g++; end
        n_checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'hFFFFFFDE || bus.rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL second_rsp got v=%b d=%h e=%b exp v=1 d=FFFFFFDE e=0", bus.rsp_valid,
                     bus.rsp_rdata, bus.rsp_err);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_out_of_range();
        logic [31:0] rd, mrd;
        logic        er, mer;
        int          lat;
        bit          to;
        model_access(1'b1, 32'h0, 2'd2, 1'b0, 32'h600DCAFE, mrd, mer);
        do_req(1'b1, 32'h0, 2'd2, 1'b0, 32'h600DCAFE, 0, rd, er, lat, to);
        do_req(1'b0, DEPTH * 4, 2'd2, 1'b0, 32'd0, 1, rd, er, lat, to);
        n_checks++;
        if (to || er !== 1'b1 || rd !== 32'd0) begin
            n_fail++; $display("FAIL oor_load got=%h err=%b exp=0 err=1", rd, er);
        end
        do_req(1'b1, DEPTH * 4, 2'd2, 1'b0, 32'hA5A5A5A5, 0, rd, er, lat, to);
        n_checks++;
        if (to || er !== 1'b1 || rd !== 32'd0) begin
            n_fail++; $display("FAIL oor_store got=%h err=%b exp=0 err=1", rd, er);
        end
        do_req(1'b0, 32'h0, 2'd2, 1'b0, 32'd0, 0, rd, er, lat, to);
        n_checks++;
        if (to || er !== 1'b0 || rd !== 32'h600DCAFE) begin
            n_fail++; $display("FAIL oor_no_write got=%h err=%b exp=600DCAFE err=0", rd, er);
        end
    endtask

    task automatic test_misalign();
        logic [31:0] rd, mrd;
        logic        er, mer;
        int          lat;
        bit          to;
        logic [31:0] exp_word;
        logic        exp_err;
`ifdef DMEM_MISALIGN_TRAP_EN
        exp_word = 32'h11223344;
        exp_err  = 1'b1;
`else
        exp_word = 32'hCAFEF00D;
        exp_err  = 1'b0;
`endif
        model_access(1'b1, 32'h20, 2'd2, 1'b0, 32'h11223344, mrd, mer);
        do_req(1'b1, 32'h20, 2'd2, 1'b0, 32'h11223344, 0, rd, er, lat, to);
        model_access(1'b1, 32'h21, 2'd2, 1'b0, 32'hCAFEF00D, mrd, mer);
        do_req(1'b1, 32'h21, 2'd2, 1'b0, 32'hCAFEF00D, 0, rd, er, lat, to);
        n_checks++;
        if (to || er !== exp_err) begin
            n_fail++; $display("FAIL misalign_store_err got=%b exp=%b", er, exp_err);
        end
        do_req(1'b0, 32'h20, 2'd2, 1'b0, 32'd0, 0, rd, er, lat, to);
        n_checks++;
        if (to || rd !== exp_word || er !== 1'b0) begin
            n_fail++; $display("FAIL misalign_word_0x20 got=%h exp=%h", rd, exp_word);
        end
    endtask

    task automatic test_reset_mid_txn();
        logic [31:0] rd, mrd;
        logic        er, mer;
        int          lat, g;
        bit          to;
        model_access(1'b1, 32'h40, 2'd2, 1'b0, 32'h0BADF00D, mrd, mer);
        do_req(1'b1, 32'h40, 2'd2, 1'b0, 32'h0BADF00D, 0, rd, er, lat, to);
        @(negedge clk);
        bus.req_we = 1'b1; bus.req_addr = 32'h40; bus.req_size = 2'd2;
        bus.req_wdata = 32'h12345678; bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_wait_state got rdy=%b v=%b exp rdy=1 v=0", bus.req_ready,
                     bus.rsp_valid);
        end
        rst = 1'b0;
        g = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b0) g++;
        end
        n_checks++;
        if (g != 0) begin
            n_fail++; $display("FAIL rst_wait_no_rsp got=%0d valid cycles exp=0", g);
        end
        do_req(1'b0, 32'h40, 2'd2, 1'b0, 32'd0, 0, rd, er, lat, to);
        n_checks++;
        if (to || rd !== 32'h0BADF00D || er !== 1'b0) begin
            n_fail++; $display("FAIL rst_wait_mem got=%h exp=0BADF00D", rd);
        end
        // Reset while a response is being held discards it.
        @(negedge clk);
        bus.req_we = 1'b0; bus.req_addr = 32'h40; bus.req_size = 2'd2; bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        g = 0;
        do begin @(negedge clk); g++; end while (bus.rsp_valid !== 1'b1 && g < 50);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== 32'd0 || bus.rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_resp_discard got v=%b d=%h e=%b exp 0/0/0", bus.rsp_valid,
                     bus.rsp_rdata, bus.rsp_err);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, mrd, addr, wd;
        logic        er, mer;
        logic [1:0]  sz;
        bit          we, un, to;
        int          lat;
        for (int i = 0; i < 64; i++) begin
            wd = $urandom;
            model_access(1'b1, 32'h100 + 4 * i, 2'd2, 1'b0, wd, mrd, mer);
            do_req(1'b1, 32'h100 + 4 * i, 2'd2, 1'b0, wd, 0, rd, er, lat, to);
            n_checks++;
            if (to || er !== 1'b0 || rd !== 32'd0) begin
                n_fail++; $display("FAIL fill_%0d got=%h err=%b exp=0 err=0", i, rd, er);
            end
        end
        for (int i = 0; i < 160; i++) begin
            we = 1'($urandom);
            un = 1'($urandom);
            sz = 2'($urandom);
            wd = $urandom;
            case ($urandom_range(0, 9))
                0:       addr = DEPTH * 4 + $urandom_range(0, 255);
                1:       addr = 32'hFFFF_FF00 + $urandom_range(0, 255);
                default: addr = 32'h100 + $urandom_range(0, 255);
            endcase
            model_access(we, addr, sz, un, wd, mrd, mer);
            do_req(we, addr, sz, un, wd, $urandom_range(0, 2), rd, er, lat, to);
            n_checks++;
            if (to || rd !== mrd || er !== mer || lat != int'(W) + 1) begin
                n_fail++;
                $display("FAIL random_%0d we=%b a=%h sz=%0d u=%b got=%h err=%b lat=%0d exp=%h err=%b lat=%0d",
                         i, we, addr, sz, un, rd, er, lat, mrd, mer, W + 1);
            end
        end
    endtask

    initial begin
        rst              = 1'b1;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_addr     = 32'd0;
        bus.req_size     = 2'd0;
        bus.req_unsigned = 1'b0;
        bus.req_wdata    = 32'd0;
        bus.rsp_ready    = 1'b0;
        test_reset();
        test_directed();
        test_backpressure();
        test_out_of_range();
        test_misalign();
        test_reset_mid_txn();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
